// File: rtl/seq_alu_acc.sv
// seq_alu_acc: sequential ALU with a 2W-bit accumulator (ALUout).
// Operand A is Data, operand B is ALUout[W-1:0]. Single-cycle ops update
// ALUout at the accepting edge. Multiply runs as a W-cycle shift-add
// sequence while Busy is high.
// Optional feature: define SEQ_ALU_SAT_EN for saturating add/subtract.
// Handshake: an operation is accepted on a rising edge where Start=1 and
// Busy=0 (and Reset_b=1). Done pulses for the one cycle after ALUout has
// been written. Start is ignored while Busy=1. A new Start may be issued
// in the same cycle Done is high.
module seq_alu_acc #(
   parameter int WIDTH = 4
) (
   input  logic                 Clock,
   input  logic                 Reset_b,
   input  logic [WIDTH-1:0]     Data,
   input  logic [2:0]           Function,
   input  logic                 Start,
   output logic                 Busy,
   output logic                 Done,
   output logic                 Flag,
   output logic [2*WIDTH-1:0]   ALUout,
   output logic                 o_dbg_state
);

   localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

   localparam logic [2:0] FN_ADD  = 3'b000;
   localparam logic [2:0] FN_MUL  = 3'b001;
   localparam logic [2:0] FN_SHL  = 3'b010;
   localparam logic [2:0] FN_HOLD = 3'b011;
   localparam logic [2:0] FN_SUB  = 3'b100;
   localparam logic [2:0] FN_AND  = 3'b101;
   localparam logic [2:0] FN_OR   = 3'b110;
   localparam logic [2:0] FN_CLR  = 3'b111;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_MUL  = 1'b1
   } state_t;

   state_t                r_state;
   logic [2*WIDTH-1:0]    r_alu;
   logic                  r_flag;
   logic                  r_busy;
   logic                  r_done;
   logic [2*WIDTH-1:0]    r_prod;
   logic [2*WIDTH-1:0]    r_mcand;
   logic [WIDTH-1:0]      r_mplier;
   logic [CW-1:0]         r_cnt;

   logic [WIDTH-1:0]      w_b;
   logic [WIDTH:0]        w_sum;
   logic [WIDTH:0]        w_diff;
   logic [2*WIDTH-1:0]    w_shl;
   logic [2*WIDTH-1:0]    w_unshl;
   logic                  w_shl_lost;
   logic [2*WIDTH-1:0]    w_prod_add;
   logic [2*WIDTH-1:0]    w_alu_nxt;
   logic                  w_flag_nxt;

   assign w_b        = r_alu[WIDTH-1:0];
   assign w_sum      = {1'b0, Data} + {1'b0, w_b};
   assign w_diff     = {1'b0, w_b} - {1'b0, Data};
   // Shifting back and comparing detects any set bit pushed past bit 2W-1;
   // amounts >= 2W give 0 both ways, so any nonzero B reports a loss.
   assign w_shl      = {{WIDTH{1'b0}}, w_b} << Data;
   assign w_unshl    = w_shl >> Data;
   assign w_shl_lost = (w_unshl != {{WIDTH{1'b0}}, w_b});
   assign w_prod_add = r_prod + (r_mplier[0] ? r_mcand : '0);

   // Next accumulator value and flag for the single-cycle operations
   always_comb begin
      w_alu_nxt  = r_alu;
      w_flag_nxt = r_flag;
      case (Function)
         FN_ADD: begin
`ifdef SEQ_ALU_SAT_EN
            if (w_sum[WIDTH]) begin
               w_alu_nxt  = {{WIDTH{1'b0}}, {WIDTH{1'b1}}};
               w_flag_nxt = 1'b1;
            end else begin
               w_alu_nxt  = {{WIDTH{1'b0}}, w_sum[WIDTH-1:0]};
               w_flag_nxt = 1'b0;
            end
`else
            w_alu_nxt  = {{(WIDTH-1){1'b0}}, w_sum};
            w_flag_nxt = w_sum[WIDTH];
`endif
         end
         FN_SUB: begin
`ifdef SEQ_ALU_SAT_EN
            if (w_diff[WIDTH]) begin
               w_alu_nxt  = '0;
               w_flag_nxt = 1'b1;
            end else begin
               w_alu_nxt  = {{WIDTH{1'b0}}, w_diff[WIDTH-1:0]};
               w_flag_nxt = 1'b0;
            end
`else
            w_alu_nxt  = {{WIDTH{1'b0}}, w_diff[WIDTH-1:0]};
            w_flag_nxt = w_diff[WIDTH];
`endif
         end
         FN_SHL: begin
            w_alu_nxt  = w_shl;
            w_flag_nxt = w_shl_lost;
         end
         FN_AND: begin
            w_alu_nxt  = {{WIDTH{1'b0}}, w_b & Data};
            w_flag_nxt = 1'b0;
         end
         FN_OR: begin
            w_alu_nxt  = {{WIDTH{1'b0}}, w_b | Data};
            w_flag_nxt = 1'b0;
         end
         FN_CLR: begin
            w_alu_nxt  = '0;
            w_flag_nxt = 1'b0;
         end
         FN_HOLD, FN_MUL: begin
            w_alu_nxt  = r_alu;
            w_flag_nxt = r_flag;
         end
         default: begin
            w_alu_nxt  = r_alu;
            w_flag_nxt = r_flag;
         end
      endcase
   end

   // Control FSM: accepts operations in IDLE, runs shift-add multiply in MUL
   always_ff @(posedge Clock) begin
      if (!Reset_b) begin
         r_state  <= ST_IDLE;
         r_alu    <= '0;
         r_flag   <= 1'b0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_prod   <= '0;
         r_mcand  <= '0;
         r_mplier <= '0;
         r_cnt    <= '0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (Start) begin
                  if (Function == FN_MUL) begin
                     r_state  <= ST_MUL;
                     r_busy   <= 1'b1;
                     r_prod   <= '0;
                     r_mcand  <= {{WIDTH{1'b0}}, Data};
                     r_mplier <= w_b;
                     r_cnt    <= '0;
                  end else begin
                     r_alu  <= w_alu_nxt;
                     r_flag <= w_flag_nxt;
                     r_done <= 1'b1;
                  end
               end
            end
            ST_MUL: begin
               // One multiplier bit per cycle; Start is ignored here
               r_prod   <= w_prod_add;
               r_mcand  <= r_mcand << 1;
               r_mplier <= r_mplier >> 1;
               r_cnt    <= r_cnt + 1'b1;
               if (r_cnt == LAST_CNT) begin
                  r_alu   <= w_prod_add;
                  r_flag  <= 1'b0;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
                  r_state <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign ALUout      = r_alu;
   assign Flag        = r_flag;
   assign Busy        = r_busy;
   assign Done        = r_done;
   assign o_dbg_state = r_state;

endmodule

// File: doc/seq_alu_acc.md
SEQ_ALU_ACC -- requirements
Module: seq_alu_acc

Interface
REQ-001 SHALL have parameter: WIDTH, 4, operand width W (2..16); result register is 2W bits.
REQ-002 SHALL have port: Clock  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port: Reset_b  input  1  synchronous, active-low reset.
REQ-004 SHALL have port: Data  input  W  operand A.
REQ-005 SHALL have port: Function  input  3  operation select, sampled when Start=1 and Busy=0.
REQ-006 SHALL have port: Start  input  1  request; one operation accepted per cycle it is high and Busy=0.
REQ-007 SHALL have port: Busy  output  1  multi-cycle multiply in progress.
REQ-008 SHALL have port: Done  output  1  one-cycle pulse when ALUout has been updated by an operation.
REQ-009 SHALL have port: Flag  output  1  carry (add), borrow (sub) or saturation event of the last completed operation.
REQ-010 SHALL have port: ALUout  output  2W  accumulator register; operand B is ALUout[W-1:0].

Function
REQ-011 SHALL decode Function: 000 add, 001 multiply, 010 shift left, 011 hold, 100 subtract, 101 AND, 110 OR, 111 clear.
REQ-012 SHALL complete all operations except multiply in one cycle: accepted at edge E, ALUout/Flag updated at E, Done=1 for the cycle after E, Busy stays 0.
REQ-013 SHALL compute add as Data + ALUout[W-1:0], zero-extended into ALUout; Flag = bit W of the sum.
REQ-014 SHALL compute subtract as ALUout[W-1:0] - Data modulo 2^W, zero-extended; Flag = borrow.
REQ-015 SHALL compute shift as ALUout[W-1:0] << Data, truncated to 2W bits; shift amounts >= 2W give 0; Flag = 1 if any set bit was shifted out.
REQ-016 SHALL compute AND/OR bitwise on low W bits with upper W bits cleared; Flag = 0.
REQ-017 SHALL, for hold, leave ALUout and Flag unchanged and still pulse Done; clear sets ALUout=0, Flag=0.
REQ-018 SHALL implement multiply as a shift-add FSM with states IDLE and MUL; IDLE->MUL on accepted Start with Function=001.
REQ-019 SHALL latch Data and ALUout[W-1:0] at acceptance edge E; Busy=1 from the cycle after E for exactly W cycles; ALUout unchanged during MUL.
REQ-020 SHALL write the 2W-bit unsigned product to ALUout at edge E+W, return to IDLE, drop Busy, Flag=0, and pulse Done for the following cycle.
REQ-021 SHALL ignore Start while Busy=1 (no queuing, no effect on the running multiply).
REQ-022 SHALL accept a new Start in the same cycle Done is high (back-to-back operations, no bubble).
REQ-023 SHALL keep Done and Busy never simultaneously high.

Reset
REQ-024 SHALL, when Reset_b=0 at a rising edge, set ALUout=0, Flag=0, Busy=0, Done=0, FSM=IDLE, overriding any Start in that cycle.
REQ-025 SHALL abort a multiply in progress on reset with no Done pulse and no ALUout write.

Configuration
REQ-026 SHALL use macro SEQ_ALU_SAT_EN to select saturating arithmetic.
REQ-027 SHALL, with SEQ_ALU_SAT_EN defined, clamp add to 2^W-1 and subtract to 0 on overflow/underflow, setting Flag=1 when clamped.
REQ-028 SHALL, without SEQ_ALU_SAT_EN, use the wrapping/extended behaviour of REQ-013/REQ-014.

Verification (WIDTH=4)
REQ-029 SHALL check add: ALUout=5, Data=3, Function=000, Start -> ALUout=8, Flag=0, Done one cycle later.
REQ-030 SHALL check multiply: ALUout=13, Data=7, Function=001 -> Busy high 4 cycles, then ALUout=91, Done pulse once.
REQ-031 SHALL check shift: ALUout=11, Data=3, Function=010 -> ALUout=88, Flag=0; Data=9 -> ALUout=0, Flag=1.
REQ-032 SHALL check Start (Function=111) issued while Busy -> ignored; multiply result 91 still written.
REQ-033 SHALL check Reset_b=0 in 2nd MUL cycle -> ALUout=0, Busy=0, no Done, FSM IDLE next cycle.
REQ-034 SHALL check ALUout=12, Data=9 add -> ALUout=15, Flag=1 with SEQ_ALU_SAT_EN; ALUout=21, Flag=1 without.
